// File: rtl/rcs_pkg.sv
// Shared definitions for the ripple counter sampler: FSM encodings and
// synchroniser depth.
package rcs_pkg;

  typedef enum logic [1:0] {
    RCS_IDLE   = 2'd0,
    RCS_SETTLE = 2'd1,
    RCS_HOLD   = 2'd2
  } rcs_state_e;

  localparam int RCS_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// WIDTH-bit two-flop synchroniser bringing asynchronous ripple counter bits
// into the clk domain; cleared by the synchronous active-low clear_n.
module sync_2ff
  import rcs_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  // p0: metastability catch flop; p1: resolved sample seen by the fabric
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/ripple_count_sampler.sv
// Request-driven sampler for an asynchronous ripple counter: synchronise,
// wait for a stable value, then present count/delta/wrap on valid/ready.
// Optional forced capture after TIMEOUT settle cycles: define RCS_TIMEOUT_EN.
module ripple_count_sampler
  import rcs_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int TIMEOUT       = 15
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] count_in,
  input  logic             sample_req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_count,
  output logic [WIDTH-1:0] out_delta,
  output logic             out_wrap,
  output logic             out_err,
  output logic             busy
);

  localparam int SC_W = $clog2(STABLE_CYCLES + 1);

  if (STABLE_CYCLES < 1 || TIMEOUT <= STABLE_CYCLES) begin : g_bad_params
    $error("ripple_count_sampler: need STABLE_CYCLES >= 1 and TIMEOUT > STABLE_CYCLES");
  end

  rcs_state_e       state;
  rcs_state_e       state_nx;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] last_q;
  logic [SC_W-1:0]  stab_cnt;
  logic             match;
  logic             hit;
  logic             forced;
  logic             capture;

  sync_2ff #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk     (clk),
    .clear_n (clear_n),
    .d       (count_in),
    .q       (sync_q)
  );

  assign match = (sync_q == prev_q);
  assign hit   = (state == RCS_SETTLE) && match &&
                 (stab_cnt == SC_W'(STABLE_CYCLES - 1));

`ifdef RCS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;

  // A normal capture on the same edge takes precedence over the timeout
  assign forced = (state == RCS_SETTLE) && !hit && (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      to_cnt <= '0;
    end else if (state == RCS_IDLE && sample_req) begin
      to_cnt <= '0;
    end else if (state == RCS_SETTLE) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      out_err <= 1'b0;
    end else if (capture) begin
      out_err <= forced;
    end
  end
`else
  assign forced  = 1'b0;
  assign out_err = 1'b0;
`endif

  assign capture = hit | forced;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state <= RCS_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RCS_IDLE:   if (sample_req) state_nx = RCS_SETTLE;
      RCS_SETTLE: if (capture)    state_nx = RCS_HOLD;
      RCS_HOLD:   if (out_ready)  state_nx = RCS_IDLE;
      default:                    state_nx = RCS_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != RCS_IDLE);
  end

  // Stability filter, capture registers and result handshake
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      prev_q    <= '0;
      last_q    <= '0;
      stab_cnt  <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_delta <= '0;
      out_wrap  <= 1'b0;
    end else begin
      unique case (state)
        RCS_IDLE: begin
          if (sample_req) begin
            prev_q   <= sync_q;
            stab_cnt <= '0;
          end
        end
        RCS_SETTLE: begin
          stab_cnt <= match ? stab_cnt + SC_W'(1) : '0;
          prev_q   <= sync_q;
          if (capture) begin
            out_count <= sync_q;
            out_delta <= sync_q - last_q;
            out_wrap  <= (sync_q < last_q);
            last_q    <= sync_q;
            out_valid <= 1'b1;
          end
        end
        RCS_HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Directed bench for ripple_count_sampler with a queue-based reference model
// compared on every falling edge; honours RCS_TIMEOUT_EN.
module tb_ripple_count_sampler;

  localparam int W  = 4;
  localparam int S  = 2;
  localparam int TO = 6;
`ifdef RCS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clear_n;
  logic [W-1:0] count_in;
  logic         sample_req;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_count;
  logic [W-1:0] out_delta;
  logic         out_wrap;
  logic         out_err;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  ripple_count_sampler #(
    .WIDTH         (W),
    .STABLE_CYCLES (S),
    .TIMEOUT       (TO)
  ) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .count_in   (count_in),
    .sample_req (sample_req),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_count  (out_count),
    .out_delta  (out_delta),
    .out_wrap   (out_wrap),
    .out_err    (out_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 settling, 2 holding a result
  int           m_mode = 0;
  int           m_nset = 0;
  logic [W-1:0] dly[$];
  logic [W-1:0] win[$];
  logic [W-1:0] m_last = '0;
  bit           e_valid = 1'b0;
  logic [W-1:0] e_count = '0;
  logic [W-1:0] e_delta = '0;
  bit           e_wrap = 1'b0;
  bit           e_err = 1'b0;

  task automatic m_capture(input logic [W-1:0] v, input bit f);
    e_count = v;
    e_delta = W'((int'(v) - int'(m_last) + (1 << W)) % (1 << W));
    e_wrap  = (int'(v) < int'(m_last));
    e_err   = f;
    m_last  = v;
    e_valid = 1'b1;
    m_mode  = 2;
  endtask

  initial begin
    logic [W-1:0] sy;
    bit           steady;
    dly.push_back('0);
    dly.push_back('0);
    forever begin
      @(posedge clk);
      sy = dly[0];
      if (!clear_n) begin
        dly.delete();
        dly.push_back('0);
        dly.push_back('0);
        m_mode = 0; m_last = '0; e_valid = 0; e_count = '0;
        e_delta = '0; e_wrap = 0; e_err = 0;
      end else begin
        void'(dly.pop_front());
        dly.push_back(count_in);
        case (m_mode)
          0: if (sample_req) begin
            win.delete();
            win.push_back(sy);
            m_nset = 0;
            m_mode = 1;
          end
          1: begin
            win.push_back(sy);
            m_nset++;
            steady = (win.size() >= S + 1);
            if (steady)
              for (int j = win.size() - S - 1; j < win.size(); j++)
                if (win[j] != sy) steady = 1'b0;
            if (steady) m_capture(sy, 1'b0);
            else if (TO_EN && m_nset == TO) m_capture(sy, 1'b1);
          end
          default: if (out_ready) begin
            e_valid = 1'b0;
            m_mode  = 0;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_valid", int'(out_valid), int'(e_valid));
    chk("cyc_count", int'(out_count), int'(e_count));
    chk("cyc_delta", int'(out_delta), int'(e_delta));
    chk("cyc_wrap",  int'(out_wrap),  int'(e_wrap));
    chk("cyc_err",   int'(out_err),   int'(e_err));
    chk("cyc_busy",  int'(busy),      int'(m_mode != 0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request();
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output int lat);
    lat = 0;
    while (!out_valid && lat < maxc) begin
      tick();
      lat++;
    end
    if (!out_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_drop", int'(out_valid), 0);
  endtask

  task automatic capture_stable(input logic [W-1:0] v, input string tag,
                                input int exp_delta, input int exp_wrap);
    int lat;
    count_in = v;
    repeat (3) tick();
    request();
    wait_valid(20, lat);
    chk({tag, "_lat"}, lat, S);
    chk({tag, "_count"}, int'(out_count), int'(v));
    chk({tag, "_delta"}, int'(out_delta), exp_delta);
    chk({tag, "_wrap"}, int'(out_wrap), exp_wrap);
    handshake();
  endtask

  initial begin
    int lat;
    clear_n = 1'b0; count_in = 4'hF; sample_req = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_count", int'(out_count), 0);
    chk("rst_delta", int'(out_delta), 0);
    chk("rst_wrap",  int'(out_wrap), 0);
    chk("rst_err",   int'(out_err), 0);
    chk("rst_busy",  int'(busy), 0);
    clear_n = 1'b1;
    capture_stable(4'hF, "first", 15, 0);

    clear_n = 1'b0; tick(); clear_n = 1'b1;
    capture_stable(4'h5, "stable5", 5, 0);
    capture_stable(4'h8, "stable8", 3, 0);
    capture_stable(4'hE, "stableE", 6, 0);
    capture_stable(4'h1, "wrap", 3, 1);

    // Toggle 7/8 continuously, request mid-stream, then settle on 8
    for (int i = 0; i < 12; i++) begin
      count_in   = (i % 2 == 0) ? 4'h7 : 4'h8;
      sample_req = (i == 2);
      tick();
    end
    sample_req = 1'b0;
    count_in   = 4'h8;
    wait_valid(30, lat);
    chk("glitch_count", int'(out_count), TO_EN ? 7 : 8);
    chk("glitch_delta", int'(out_delta), TO_EN ? 6 : 7);
    chk("glitch_wrap",  int'(out_wrap), 0);
    chk("glitch_err",   int'(out_err), TO_EN ? 1 : 0);
    handshake();

    count_in = 4'h9;
    repeat (3) tick();
    request();
    wait_valid(20, lat);
    chk("bp_count", int'(out_count), 9);
    chk("bp_delta", int'(out_delta), TO_EN ? 2 : 1);
    for (int i = 0; i < 5; i++) begin
      sample_req = (i % 2 == 0);
      count_in   = W'(i + 10);
      tick();
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_count", int'(out_count), 9);
    end
    sample_req = 1'b1;
    out_ready  = 1'b1;
    tick();
    chk("bp_exit_valid", int'(out_valid), 0);
    sample_req = 1'b0;
    out_ready  = 1'b0;
    repeat (4) begin
      tick();
      chk("bp_no_second", int'(out_valid), 0);
      chk("bp_idle_busy", int'(busy), 0);
    end

    count_in = 4'h7;
    repeat (3) tick();
    request();
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    chk("midrst_busy",  int'(busy), 0);
    chk("midrst_valid", int'(out_valid), 0);
    capture_stable(4'h3, "post_rst", 3, 0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ripple_count_sampler.md
# ripple_count_sampler

Samples the asynchronous output of the ripple counter into the `clk` domain on request. Each bit is double-flop synchronised and a stability filter is applied, because ripple bits settle at different times. The captured value, its modular delta from the previous capture and a wrap flag are presented on a valid/ready interface. The block sits directly downstream of the ripple counter and feeds synchronous logic.

## Interface
- `WIDTH`, 4: counter width in bits.
- `STABLE_CYCLES`, 2: consecutive equal synchronised samples required before capture; must be ≥1.
- `TIMEOUT`, 15: maximum SETTLE cycles before a forced capture; must be > `STABLE_CYCLES`. Used only with `RCS_TIMEOUT_EN`.

- `clk`  in  1  single clock, rising edge.
- `clear_n`  in  1  reset, synchronous, active-low.
- `count_in`  in  WIDTH  raw ripple counter bits, asynchronous to `clk`.
- `sample_req`  in  1  capture request, sampled in IDLE only.
- `out_ready`  in  1  consumer accepts the result.
- `out_valid`  out  1  result available.
- `out_count`  out  WIDTH  captured count.
- `out_delta`  out  WIDTH  `out_count` minus previous capture, mod 2^WIDTH.
- `out_wrap`  out  1  `out_count` < previous capture (unsigned).
- `out_err`  out  1  capture was forced by timeout.
- `busy`  out  1  state ≠ IDLE.

## Operation
- The synchroniser runs continuously: two flops per bit, giving `sync_q`.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE + `sample_req`=1:
  - go to SETTLE.
  - `prev_q`<=`sync_q`, `stab_cnt`<=0, `to_cnt`<=0.
- SETTLE, each edge:
  - If `sync_q`==`prev_q`, `stab_cnt`++; otherwise `stab_cnt`<=0.
  - `prev_q`<=`sync_q`; `to_cnt`++.
- Capture happens on the edge where `sync_q`==`prev_q` and `stab_cnt`==`STABLE_CYCLES`-1. On that edge:
  - `out_count`<=`sync_q`.
  - `out_delta`<=`sync_q`-`last_q` (mod 2^WIDTH).
  - `out_wrap`<=(`sync_q`<`last_q`).
  - `last_q`<=`sync_q`.
  - `out_valid`<=1; go to HOLD.
- HOLD:
  - All outputs are held stable while `out_ready`=0.
  - On an edge with `out_ready`=1: `out_valid`<=0, go to IDLE.
- `sample_req` in SETTLE or HOLD is ignored, including in the HOLD exit cycle. There is no queuing.
- `out_count`/`out_delta`/`out_wrap`/`out_err` keep their last values after the handshake completes.
- Reset, including mid-SETTLE or mid-HOLD, clears:
  - all outputs to 0.
  - `last_q`, `prev_q`, the synchroniser flops and all counters to 0.
  - state to IDLE. Any pending result is discarded.
- The first capture after reset measures its delta against 0.

## Timing
- Reset values: every output is 0.
- With `sync_q` stable, `out_valid` rises `STABLE_CYCLES` edges after the edge that samples `sample_req`. The default is 2.
- A change on `count_in` reaches `sync_q` after 2 edges. The block does not compensate for this lag.
- Any mismatch restarts the stability count. Capture is therefore delayed indefinitely while the counter keeps changing, unless the timeout is enabled.
- `out_valid` falls on the edge where `out_valid`&`out_ready`. The earliest next request is the edge after that.
- `busy` is combinational from state.

## Configuration
- `RCS_TIMEOUT_EN` defined:
  - In SETTLE, on the edge where `to_cnt`==`TIMEOUT`-1 with no normal capture, capture `sync_q` as normal and set `out_err`<=1.
  - A normal capture sets `out_err`<=0.
  - If both conditions hold on the same edge, the capture is normal with `out_err`=0.
- `RCS_TIMEOUT_EN` not defined:
  - No `to_cnt`; `TIMEOUT` is ignored; `out_err` is tied to 0.

## Structure
- Shared package/include `rcs_pkg`:
  - FSM state encodings `RCS_IDLE`=2'd0, `RCS_SETTLE`=2'd1, `RCS_HOLD`=2'd2.
  - synchroniser depth constant `RCS_SYNC_STAGES`=2.
- One sub-module, `sync_2ff`: a WIDTH-parameterised two-flop synchroniser with `clk`/`clear_n`. It is instantiated once.
- The FSM, stability filter, delta logic and timeout live in the top module.

## Test plan
- Reset: hold `clear_n`=0 for 3 cycles with `count_in`=4'hF. Expect all outputs 0 and `busy`=0. A capture requested after release returns `out_count`=F, `out_delta`=F, `out_wrap`=0.
- Stable capture: `count_in`=4'h5 for ≥3 cycles, pulse `sample_req`. Expect `out_valid` 2 edges later with `out_count`=5 and `out_delta`=5. Then set `count_in`=8 and request again: expect `out_delta`=3, `out_wrap`=0.
- Wrap: previous capture 4'hE, `count_in`=4'h1. Expect `out_count`=1, `out_delta`=3, `out_wrap`=1.
- Glitchy input:
  - Toggle `count_in` between 7 and 8 every cycle for 10 cycles after the request, then hold 8.
  - With the macro off: capture `out_count`=8, `out_err`=0.
  - With `RCS_TIMEOUT_EN` and `TIMEOUT`=6 under continuous toggling: forced capture on the 6th SETTLE edge with `out_err`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles while pulsing `sample_req` and changing `count_in`. Expect outputs unchanged and `out_valid` held. `out_ready`=1 drops `out_valid` next edge; the ignored requests produce no second result.
- Reset mid-SETTLE: drive `clear_n`=0 one cycle after the request. Expect IDLE, `out_valid`=0 and `last_q` cleared; the next capture of 3 gives `out_delta`=3.
